// File: rtl/sub_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sub_bus_arbiter_pkg
//   Sub-bus widths and field positions shared by the sub-bus arbiter and
//   anything else that drives or decodes sub_bus_in / sub_bus_out.
//
//   sub_bus_in  layout (LSB first):
//     CLK | RESET_L | STARTUP | REQ | RD_WR_L | ADDR[15:0] | DATA[31:0]
//   sub_bus_out layout (LSB first):
//     ACK | RD_DATA[31:0] | IRQ
// ---------------------------------------------------------------------------
package sub_bus_arbiter_pkg;

  localparam int BUS_ADDR_WIDTH = 16;
  localparam int BUS_DATA_WIDTH = 32;

  // Request side field positions
  localparam int BUS_IN_CLK      = 0;
  localparam int BUS_IN_RESET_L  = 1;
  localparam int BUS_IN_STARTUP  = 2;
  localparam int BUS_IN_REQ      = 3;
  localparam int BUS_IN_RD_WR_L  = 4;
  localparam int BUS_IN_ADDR_LSB = 5;
  localparam int BUS_IN_DATA_LSB = BUS_IN_ADDR_LSB + BUS_ADDR_WIDTH;
  localparam int BUS_IN_WIDTH    = BUS_IN_DATA_LSB + BUS_DATA_WIDTH;

  // Response side field positions
  localparam int BUS_OUT_ACK         = 0;
  localparam int BUS_OUT_RD_DATA_LSB = 1;
  localparam int BUS_OUT_IRQ         = BUS_OUT_RD_DATA_LSB + BUS_DATA_WIDTH;
  localparam int BUS_OUT_WIDTH       = BUS_OUT_IRQ + 1;

  // One latched master command: everything the bus needs besides REQ.
  typedef struct packed {
    logic                      rd_wr_l;
    logic [BUS_ADDR_WIDTH-1:0] addr;
    logic [BUS_DATA_WIDTH-1:0] wr_data;
  } bus_cmd_t;

  // Assemble the sub_bus_in vector from its fields.
  function automatic logic [BUS_IN_WIDTH-1:0] bus_in_pack(
    input logic     clk,
    input logic     reset_l,
    input logic     startup,
    input logic     req,
    input bus_cmd_t cmd
  );
    logic [BUS_IN_WIDTH-1:0] v;
    v = '0;
    v[BUS_IN_CLK]                                = clk;
    v[BUS_IN_RESET_L]                            = reset_l;
    v[BUS_IN_STARTUP]                            = startup;
    v[BUS_IN_REQ]                                = req;
    v[BUS_IN_RD_WR_L]                            = cmd.rd_wr_l;
    v[BUS_IN_ADDR_LSB +: BUS_ADDR_WIDTH]         = cmd.addr;
    v[BUS_IN_DATA_LSB +: BUS_DATA_WIDTH]         = cmd.wr_data;
    return v;
  endfunction

endpackage

// File: rtl/sub_bus_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Scans the request vector starting at
//   the pointer position and wrapping around; the first set bit wins.
//
//   Ports:
//     req    in   N       request vector
//     ptr    in   IDX_W   highest-priority position this round (0..N-1)
//     grant  out  N       one-hot grant (all zero when no request)
//     idx    out  IDX_W   index of the granted bit (0 when no request)
//     any    out  1       at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int pos;
    pos   = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int off = 0; off < N; off++) begin
      // ptr never exceeds N-1, so one conditional subtract is a full modulo
      pos = int'(ptr) + off;
      if (pos >= N) pos = pos - N;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/sub_bus_arbiter.sv
// ---------------------------------------------------------------------------
// sub_bus_arbiter
//   Shares one sub-bus between NUM_MASTERS local masters. Round-robin grant,
//   a single transaction in flight, and a per-transaction ack timeout that
//   completes the transaction with an error and TIMEOUT_DATA.
//
//   Ports:
//     sub_clk      in   1                            clock for all logic
//     sub_reset_l  in   1                            async active-low reset
//     sub_startup  in   1                            forwarded to sub_bus_in STARTUP
//     m_req        in   NUM_MASTERS                  per-master request level
//     m_rd_wr_l    in   NUM_MASTERS                  per-master 1=read 0=write
//     m_addr       in   NUM_MASTERS*BUS_ADDR_WIDTH   master i at [i*AW +: AW]
//     m_wr_data    in   NUM_MASTERS*BUS_DATA_WIDTH   master i at [i*DW +: DW]
//     m_ack        out  NUM_MASTERS                  one-cycle completion pulse
//     m_err        out  1                            with m_ack: 1 = timed out
//     m_rd_data    out  BUS_DATA_WIDTH               read data, valid with m_ack
//     sub_bus_in   out  BUS_IN_WIDTH                 sub-bus request side
//     sub_bus_out  in   BUS_OUT_WIDTH                sub-bus response side
//     sub_irq      out  1                            sub_bus_out IRQ pass-through
//
//   Transaction timeline (cycle numbers):
//     0 IDLE (pick + latch) | 1 ISSUE (REQ=1) | 2..k WAIT | k+1 DONE (m_ack)
// ---------------------------------------------------------------------------
module sub_bus_arbiter
  import sub_bus_arbiter_pkg::*;
#(
  parameter int                        NUM_MASTERS  = 4,
  parameter int                        TIMEOUT      = 255,
  parameter logic [BUS_DATA_WIDTH-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic                                  sub_clk,
  input  logic                                  sub_reset_l,
  input  logic                                  sub_startup,
  input  logic [NUM_MASTERS-1:0]                m_req,
  input  logic [NUM_MASTERS-1:0]                m_rd_wr_l,
  input  logic [NUM_MASTERS*BUS_ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*BUS_DATA_WIDTH-1:0] m_wr_data,
  output logic [NUM_MASTERS-1:0]                m_ack,
  output logic                                  m_err,
  output logic [BUS_DATA_WIDTH-1:0]             m_rd_data,
  output logic [BUS_IN_WIDTH-1:0]               sub_bus_in,
  input  logic [BUS_OUT_WIDTH-1:0]              sub_bus_out,
  output logic                                  sub_irq
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = 16;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MASTERS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]                state;
  logic [IDX_W-1:0]          rr_ptr;
  logic [IDX_W-1:0]          winner_q;
  logic [NUM_MASTERS-1:0]    grant_q;
  bus_cmd_t                  cmd_q;
  logic                      bus_req_q;
  logic [CNT_W-1:0]          tmo_cnt;
  logic [NUM_MASTERS-1:0]    m_ack_q;
  logic                      m_err_q;
  logic [BUS_DATA_WIDTH-1:0] m_rd_data_q;

  logic [NUM_MASTERS-1:0]    pick_grant;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_any;
  bus_cmd_t                  sel_cmd;
  logic [IDX_W-1:0]          rr_next;

  logic                      bus_ack;
  logic [BUS_DATA_WIDTH-1:0] bus_rd_data;

  // Response-side field decode
  assign bus_ack     = sub_bus_out[BUS_OUT_ACK];
  assign bus_rd_data = sub_bus_out[BUS_OUT_RD_DATA_LSB +: BUS_DATA_WIDTH];
  assign sub_irq     = sub_bus_out[BUS_OUT_IRQ];

  rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (m_req),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Only the picked master's command is muxed through; other masters'
  // address and write data never reach the latch or the bus.
  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_cmd.rd_wr_l = m_rd_wr_l[i];
        sel_cmd.addr    = m_addr[i*BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH];
        sel_cmd.wr_data = m_wr_data[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
      end
    end
  end

  // Priority moves to the master just after the one served
  assign rr_next = (winner_q == IDX_LAST) ? '0 : winner_q + IDX_W'(1);

  always_ff @(posedge sub_clk or negedge sub_reset_l) begin
    if (!sub_reset_l) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      winner_q    <= '0;
      grant_q     <= '0;
      cmd_q       <= '0;
      bus_req_q   <= 1'b0;
      tmo_cnt     <= '0;
      m_ack_q     <= '0;
      m_err_q     <= 1'b0;
      m_rd_data_q <= '0;
    end else begin
      case (state)
        // IDLE: pick a winner and latch its command
        ST_IDLE: begin
          if (pick_any) begin
            cmd_q     <= sel_cmd;
            grant_q   <= pick_grant;
            winner_q  <= pick_idx;
            bus_req_q <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        // ISSUE: REQ is high for exactly this cycle; acks here are ignored
        ST_ISSUE: begin
          bus_req_q <= 1'b0;
          tmo_cnt   <= '0;
          state     <= ST_WAIT;
        end
        // WAIT: ack is tested before the timeout so an ack on the last
        // counted cycle still completes successfully
        ST_WAIT: begin
          if (bus_ack) begin
            m_ack_q     <= grant_q;
            m_err_q     <= 1'b0;
            m_rd_data_q <= bus_rd_data;
            state       <= ST_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            m_ack_q     <= grant_q;
            m_err_q     <= 1'b1;
            m_rd_data_q <= TIMEOUT_DATA;
            state       <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        // DONE: m_ack/m_err are visible this cycle; m_rd_data is held
        ST_DONE: begin
          m_ack_q <= '0;
          m_err_q <= 1'b0;
          rr_ptr  <= rr_next;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_ack     = m_ack_q;
  assign m_err     = m_err_q;
  assign m_rd_data = m_rd_data_q;

  // CLK, RESET_L and STARTUP are forwarded combinationally; the rest is registered
  assign sub_bus_in = bus_in_pack(sub_clk, sub_reset_l, sub_startup, bus_req_q, cmd_q);

endmodule

// File: tb/tb_sub_bus_arbiter.sv
module tb_sub_bus_arbiter;
  import sub_bus_arbiter_pkg::*;

  localparam int          NM    = 4;
  localparam int          TMO   = 8;
  localparam logic [31:0] TDATA = 32'hDEAD_BEEF;
  localparam int          AW    = BUS_ADDR_WIDTH;
  localparam int          DW    = BUS_DATA_WIDTH;

  logic                   sub_clk     = 1'b0;
  logic                   sub_reset_l = 1'b0;
  logic                   sub_startup = 1'b0;
  logic [NM-1:0]          m_req       = '0;
  logic [NM-1:0]          m_rd_wr_l   = '0;
  logic [NM*AW-1:0]       m_addr      = '0;
  logic [NM*DW-1:0]       m_wr_data   = '0;
  logic [NM-1:0]          m_ack;
  logic                   m_err;
  logic [DW-1:0]          m_rd_data;
  logic [BUS_IN_WIDTH-1:0]  sub_bus_in;
  logic [BUS_OUT_WIDTH-1:0] sub_bus_out = '0;
  logic                   sub_irq;

  sub_bus_arbiter #(
    .NUM_MASTERS  (NM),
    .TIMEOUT      (TMO),
    .TIMEOUT_DATA (TDATA)
  ) dut (
    .sub_clk     (sub_clk),
    .sub_reset_l (sub_reset_l),
    .sub_startup (sub_startup),
    .m_req       (m_req),
    .m_rd_wr_l   (m_rd_wr_l),
    .m_addr      (m_addr),
    .m_wr_data   (m_wr_data),
    .m_ack       (m_ack),
    .m_err       (m_err),
    .m_rd_data   (m_rd_data),
    .sub_bus_in  (sub_bus_in),
    .sub_bus_out (sub_bus_out),
    .sub_irq     (sub_irq)
  );

  always #5 sub_clk = ~sub_clk;

  int cyc = 0;
  always @(posedge sub_clk) cyc <= cyc + 1;

  logic          bus_req, bus_rd_wr_l, bus_startup, bus_reset_l;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_data;
  assign bus_req     = sub_bus_in[BUS_IN_REQ];
  assign bus_rd_wr_l = sub_bus_in[BUS_IN_RD_WR_L];
  assign bus_startup = sub_bus_in[BUS_IN_STARTUP];
  assign bus_reset_l = sub_bus_in[BUS_IN_RESET_L];
  assign bus_addr    = sub_bus_in[BUS_IN_ADDR_LSB +: AW];
  assign bus_data    = sub_bus_in[BUS_IN_DATA_LSB +: DW];

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          master;
    logic        err;
    logic [31:0] data;
    bit          chk_data;
  } exp_t;
  exp_t sb[$];

  // Slave model: acks slave_delay cycles after the REQ cycle (0 = never)
  int          slave_delay = 0;
  logic [31:0] slave_data  = '0;
  bit          slave_addr_mode = 1'b0;
  int          stray_cycle = -1;
  logic        slave_irq = 1'b0;
  int          cd = 0;
  logic [AW-1:0] req_addr_seen = '0;

  always @(negedge sub_clk) begin
    logic        a;
    logic [31:0] d;
    a = 1'b0;
    if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) a = 1'b1;
    end
    if (bus_req === 1'b1) begin
      cd = slave_delay;
      req_addr_seen = bus_addr;
    end
    if (cyc == stray_cycle) a = 1'b1;
    d = slave_addr_mode ? {16'hA000, req_addr_seen} : slave_data;
    sub_bus_out = '0;
    sub_bus_out[BUS_OUT_ACK] = a;
    sub_bus_out[BUS_OUT_RD_DATA_LSB +: DW] = d;
    sub_bus_out[BUS_OUT_IRQ] = slave_irq;
  end

  // Invariant watchers, compared in test_invariants
  int   inv_onehot = 0;
  int   inv_err = 0;
  int   inv_req2 = 0;
  logic prev_req = 1'b0;
  always @(negedge sub_clk) begin
    if ($countones(m_ack) > 1) inv_onehot++;
    if (m_ack === '0 && m_err !== 1'b0) inv_err++;
    if (prev_req === 1'b1 && bus_req === 1'b1) inv_req2++;
    prev_req = bus_req;
  end

  task automatic wait_req(output int c, output bit ok);
    ok = 1'b0;
    c = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge sub_clk);
      if (bus_req === 1'b1) begin
        ok = 1'b1;
        c = cyc;
        break;
      end
    end
  endtask

  task automatic wait_ack(output int c, output int idx, output logic e,
                          output logic [31:0] d, output bit ok);
    ok = 1'b0;
    c = -1;
    idx = -1;
    e = 1'bx;
    d = 'x;
    for (int i = 0; i < 64; i++) begin
      @(negedge sub_clk);
      if (m_ack !== '0) begin
        ok = 1'b1;
        c = cyc;
        e = m_err;
        d = m_rd_data;
        for (int j = 0; j < NM; j++) if (m_ack[j] === 1'b1) idx = j;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge sub_clk);
    sub_reset_l = 1'b0;
    m_req = '0;
    sb.delete();
    repeat (3) @(negedge sub_clk);
    sub_reset_l = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge sub_clk);
    sub_reset_l = 1'b0;
    sub_startup = 1'b1;
    slave_irq = 1'b1;
    @(negedge sub_clk);
    #1;
    checks++; if (m_ack !== '0) begin failures++; $display("FAIL reset_m_ack got=%b exp=0", m_ack); end
    checks++; if (m_err !== 1'b0) begin failures++; $display("FAIL reset_m_err got=%b exp=0", m_err); end
    checks++; if (m_rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", m_rd_data); end
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL reset_bus_req got=%b exp=0", bus_req); end
    checks++; if (bus_addr !== '0 || bus_data !== '0 || bus_rd_wr_l !== 1'b0) begin
      failures++; $display("FAIL reset_bus_cmd got=%h/%h/%b exp=0/0/0", bus_addr, bus_data, bus_rd_wr_l); end
    checks++; if (bus_startup !== 1'b1) begin failures++; $display("FAIL startup_fwd_hi got=%b exp=1", bus_startup); end
    checks++; if (bus_reset_l !== 1'b0) begin failures++; $display("FAIL reset_l_fwd_lo got=%b exp=0", bus_reset_l); end
    checks++; if (sub_irq !== 1'b1) begin failures++; $display("FAIL irq_pass_hi got=%b exp=1", sub_irq); end
    sub_startup = 1'b0;
    slave_irq = 1'b0;
    sub_reset_l = 1'b1;
    @(negedge sub_clk);
    #1;
    checks++; if (bus_startup !== 1'b0) begin failures++; $display("FAIL startup_fwd_lo got=%b exp=0", bus_startup); end
    checks++; if (bus_reset_l !== 1'b1) begin failures++; $display("FAIL reset_l_fwd_hi got=%b exp=1", bus_reset_l); end
    checks++; if (sub_irq !== 1'b0) begin failures++; $display("FAIL irq_pass_lo got=%b exp=0", sub_irq); end
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL idle_no_req got=%b exp=0", bus_req); end
  endtask

  task automatic test_single_read();
    int c0, r, k, idx;
    bit ok;
    logic e;
    logic [31:0] d;
    exp_t x;
    slave_delay = 3;
    slave_data = 32'h1234_5678;
    slave_addr_mode = 1'b0;
    @(negedge sub_clk);
    m_addr[0 +: AW] = 16'h0040;
    m_rd_wr_l[0] = 1'b1;
    m_req = 4'b0001;
    c0 = cyc;
    sb.push_back('{0, 1'b0, 32'h1234_5678, 1'b1});
    wait_req(r, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rd_req_seen got=none exp=REQ"); end
    checks++; if (r != c0 + 1) begin failures++; $display("FAIL rd_req_latency got=%0d exp=%0d", r - c0, 1); end
    checks++; if (bus_addr !== 16'h0040) begin failures++; $display("FAIL rd_addr got=%h exp=0040", bus_addr); end
    checks++; if (bus_rd_wr_l !== 1'b1) begin failures++; $display("FAIL rd_rd_wr_l got=%b exp=1", bus_rd_wr_l); end
    @(negedge sub_clk);
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL rd_req_one_cycle got=%b exp=0", bus_req); end
    wait_ack(k, idx, e, d, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rd_ack_seen got=none exp=m_ack"); end
    checks++; if (k != r + 4) begin failures++; $display("FAIL rd_ack_latency got=%0d exp=%0d", k - r, 4); end
    checks++; if (sb.size() == 0) begin failures++; $display("FAIL rd_sb_empty got=0 exp=1"); end
    else begin
      x = sb.pop_front();
      checks++; if (idx != x.master) begin failures++; $display("FAIL rd_master got=%0d exp=%0d", idx, x.master); end
      checks++; if (e !== x.err) begin failures++; $display("FAIL rd_err got=%b exp=%b", e, x.err); end
      checks++; if (d !== x.data) begin failures++; $display("FAIL rd_data got=%h exp=%h", d, x.data); end
    end
    @(negedge sub_clk);
    checks++; if (m_ack !== '0 || m_err !== 1'b0) begin
      failures++; $display("FAIL rd_ack_one_cycle got=%b/%b exp=0/0", m_ack, m_err); end
    m_req = '0;
  endtask

  task automatic test_fairness();
    int k, idx, prev;
    bit ok;
    logic e;
    logic [31:0] d;
    exp_t x;
    do_reset();
    slave_delay = 1;
    slave_addr_mode = 1'b1;
    @(negedge sub_clk);
    for (int i = 0; i < NM; i++) m_addr[i*AW +: AW] = 16'(16'h0101 * i);
    m_rd_wr_l = '1;
    m_req = '1;
    for (int n = 0; n < 8; n++) sb.push_back('{n % NM, 1'b0, {16'hA000, 16'(16'h0101 * (n % NM))}, 1'b1});
    prev = -1;
    for (int n = 0; n < 8; n++) begin
      wait_ack(k, idx, e, d, ok);
      checks++; if (!ok) begin failures++; $display("FAIL fair_ack_seen n=%0d got=none exp=m_ack", n); end
      x = sb.pop_front();
      checks++; if (idx != x.master) begin failures++; $display("FAIL fair_order n=%0d got=%0d exp=%0d", n, idx, x.master); end
      checks++; if (d !== x.data || e !== x.err) begin
        failures++; $display("FAIL fair_data n=%0d got=%h/%b exp=%h/%b", n, d, e, x.data, x.err); end
      if (n > 0) begin
        checks++; if (k - prev != 4) begin failures++; $display("FAIL fair_spacing n=%0d got=%0d exp=4", n, k - prev); end
      end
      prev = k;
    end
    @(negedge sub_clk);
    m_req = '0;
  endtask

  task automatic test_timeout();
    int r, k, idx;
    bit ok, quiet;
    logic e;
    logic [31:0] d;
    exp_t x;
    slave_delay = 0;
    slave_addr_mode = 1'b0;
    slave_data = 32'h5555_AAAA;
    @(negedge sub_clk);
    m_addr[1*AW +: AW] = 16'h0222;
    m_rd_wr_l[1] = 1'b1;
    m_req = 4'b0010;
    sb.push_back('{1, 1'b1, TDATA, 1'b1});
    wait_req(r, ok);
    checks++; if (!ok) begin failures++; $display("FAIL tmo_req_seen got=none exp=REQ"); end
    stray_cycle = r + TMO + 3;
    wait_ack(k, idx, e, d, ok);
    checks++; if (!ok) begin failures++; $display("FAIL tmo_ack_seen got=none exp=m_ack"); end
    checks++; if (k != r + TMO + 1) begin failures++; $display("FAIL tmo_latency got=%0d exp=%0d", k - r, TMO + 1); end
    x = sb.pop_front();
    checks++; if (idx != x.master) begin failures++; $display("FAIL tmo_master got=%0d exp=%0d", idx, x.master); end
    checks++; if (e !== x.err) begin failures++; $display("FAIL tmo_err got=%b exp=%b", e, x.err); end
    checks++; if (d !== x.data) begin failures++; $display("FAIL tmo_data got=%h exp=%h", d, x.data); end
    @(negedge sub_clk);
    m_req = '0;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sub_clk);
      if (m_ack !== '0 || bus_req !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin failures++; $display("FAIL stray_ack_ignored got=activity exp=quiet"); end
    stray_cycle = -1;
  endtask

  task automatic test_write();
    int r, k, idx;
    bit ok;
    logic e;
    logic [31:0] d;
    exp_t x;
    logic [AW-1:0] ea [2];
    logic [DW-1:0] ed [2];
    slave_delay = 2;
    slave_addr_mode = 1'b0;
    slave_data = 32'h0BAD_F00D;
    ea[0] = 16'h0010; ed[0] = 32'hA5A5_0000;
    ea[1] = 16'h0777; ed[1] = 32'h1357_9BDF;
    @(negedge sub_clk);
    m_addr[2*AW +: AW] = ea[0];
    m_wr_data[2*DW +: DW] = ed[0];
    m_addr[0 +: AW] = ea[1];
    m_wr_data[0 +: DW] = ed[1];
    m_wr_data[1*DW +: DW] = 32'hFFFF_FFFF;
    m_wr_data[3*DW +: DW] = 32'hEEEE_EEEE;
    m_rd_wr_l = 4'b1010;
    m_req = 4'b0101;
    sb.push_back('{2, 1'b0, 32'h0, 1'b0});
    sb.push_back('{0, 1'b0, 32'h0, 1'b0});
    for (int n = 0; n < 2; n++) begin
      wait_req(r, ok);
      checks++; if (!ok) begin failures++; $display("FAIL wr_req_seen n=%0d got=none exp=REQ", n); end
      checks++; if (bus_rd_wr_l !== 1'b0) begin failures++; $display("FAIL wr_rd_wr_l n=%0d got=%b exp=0", n, bus_rd_wr_l); end
      checks++; if (bus_addr !== ea[n]) begin failures++; $display("FAIL wr_addr n=%0d got=%h exp=%h", n, bus_addr, ea[n]); end
      checks++; if (bus_data !== ed[n]) begin failures++; $display("FAIL wr_data n=%0d got=%h exp=%h", n, bus_data, ed[n]); end
      wait_ack(k, idx, e, d, ok);
      checks++; if (!ok || k != r + 3) begin failures++; $display("FAIL wr_ack_latency n=%0d got=%0d exp=3", n, k - r); end
      x = sb.pop_front();
      checks++; if (idx != x.master) begin failures++; $display("FAIL wr_master n=%0d got=%0d exp=%0d", n, idx, x.master); end
      checks++; if (e !== x.err) begin failures++; $display("FAIL wr_err n=%0d got=%b exp=%b", n, e, x.err); end
      if (x.chk_data) begin
        checks++; if (d !== x.data) begin failures++; $display("FAIL wr_rd_data n=%0d got=%h exp=%h", n, d, x.data); end
      end
      @(negedge sub_clk);
      m_req[x.master] = 1'b0;
    end
  endtask

  task automatic test_reset_in_wait();
    int r, k, idx;
    bit ok, quiet;
    logic e;
    logic [31:0] d;
    exp_t x;
    slave_delay = 0;
    slave_addr_mode = 1'b0;
    @(negedge sub_clk);
    m_addr[3*AW +: AW] = 16'h0333;
    m_rd_wr_l = '1;
    m_req = 4'b1000;
    wait_req(r, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstw_req_seen got=none exp=REQ"); end
    repeat (2) @(negedge sub_clk);
    #2;
    sub_reset_l = 1'b0;
    #1;
    checks++; if (m_ack !== '0 || m_err !== 1'b0) begin
      failures++; $display("FAIL rstw_ack_err got=%b/%b exp=0/0", m_ack, m_err); end
    checks++; if (m_rd_data !== '0) begin failures++; $display("FAIL rstw_rd_data got=%h exp=0", m_rd_data); end
    checks++; if (bus_req !== 1'b0 || bus_addr !== '0 || bus_data !== '0 || bus_rd_wr_l !== 1'b0) begin
      failures++; $display("FAIL rstw_bus got=%b/%h/%h/%b exp=0/0/0/0", bus_req, bus_addr, bus_data, bus_rd_wr_l); end
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sub_clk);
      if (m_ack !== '0 || bus_req !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin failures++; $display("FAIL rstw_quiet got=activity exp=quiet"); end
    m_addr[0 +: AW] = 16'h0044;
    m_req = 4'b1001;
    slave_delay = 1;
    slave_addr_mode = 1'b1;
    sb.push_back('{0, 1'b0, 32'hA000_0044, 1'b1});
    sb.push_back('{3, 1'b0, 32'hA000_0333, 1'b1});
    sub_reset_l = 1'b1;
    for (int n = 0; n < 2; n++) begin
      wait_ack(k, idx, e, d, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rstw_ack_seen n=%0d got=none exp=m_ack", n); end
      x = sb.pop_front();
      checks++; if (idx != x.master) begin failures++; $display("FAIL rstw_order n=%0d got=%0d exp=%0d", n, idx, x.master); end
      checks++; if (d !== x.data || e !== x.err) begin
        failures++; $display("FAIL rstw_data n=%0d got=%h/%b exp=%h/%b", n, d, e, x.data, x.err); end
      @(negedge sub_clk);
      m_req[x.master] = 1'b0;
    end
  endtask

  task automatic test_ack_last_cycle();
    int r, k, idx;
    bit ok, quiet;
    logic e;
    logic [31:0] d;
    exp_t x;
    int dly [2];
    dly[0] = TMO;
    dly[1] = TMO + 1;
    slave_addr_mode = 1'b0;
    slave_data = 32'h600D_DA7A;
    sb.push_back('{1, 1'b0, 32'h600D_DA7A, 1'b1});
    sb.push_back('{1, 1'b1, TDATA, 1'b1});
    for (int n = 0; n < 2; n++) begin
      slave_delay = dly[n];
      @(negedge sub_clk);
      m_addr[1*AW +: AW] = 16'h0111;
      m_rd_wr_l[1] = 1'b1;
      m_req = 4'b0010;
      wait_req(r, ok);
      checks++; if (!ok) begin failures++; $display("FAIL last_req_seen n=%0d got=none exp=REQ", n); end
      wait_ack(k, idx, e, d, ok);
      checks++; if (!ok || k != r + TMO + 1) begin
        failures++; $display("FAIL last_latency n=%0d got=%0d exp=%0d", n, k - r, TMO + 1); end
      x = sb.pop_front();
      checks++; if (idx != x.master) begin failures++; $display("FAIL last_master n=%0d got=%0d exp=%0d", n, idx, x.master); end
      checks++; if (e !== x.err) begin failures++; $display("FAIL last_err n=%0d got=%b exp=%b", n, e, x.err); end
      checks++; if (d !== x.data) begin failures++; $display("FAIL last_data n=%0d got=%h exp=%h", n, d, x.data); end
      @(negedge sub_clk);
      m_req = '0;
      quiet = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge sub_clk);
        if (m_ack !== '0) quiet = 1'b0;
      end
      checks++; if (!quiet) begin failures++; $display("FAIL last_no_extra_ack n=%0d got=ack exp=none", n); end
    end
  endtask

  task automatic test_invariants();
    checks++; if (inv_onehot != 0) begin failures++; $display("FAIL inv_ack_onehot got=%0d exp=0", inv_onehot); end
    checks++; if (inv_err != 0) begin failures++; $display("FAIL inv_err_without_ack got=%0d exp=0", inv_err); end
    checks++; if (inv_req2 != 0) begin failures++; $display("FAIL inv_req_multi_cycle got=%0d exp=0", inv_req2); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_timeout();
    test_write();
    test_reset_in_wait();
    test_ack_last_cycle();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
